uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (TX FIFO write side: wr_uart / w_data / tx_full) between NREQ independent requesters.
- Each requester sends multi-byte messages; the grant is held from first byte to the byte flagged last, so messages never interleave.
- Round-robin fairness between requesters; a stall watchdog reclaims the channel from a stalled requester.
- Sits between the client logic (command responders, status reporters) and the uart top-level transmit interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; must equal ceil(log2(NREQ)).
- DBIT, 8, data byte width; matches the UART data width.
- STALL_MAX, 255, cycles of req_valid low mid-message before the grant is revoked (1..65535).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i presents a byte.
- req_data  input  NREQ*DBIT  requester i byte at bits [i*DBIT +: DBIT].
- req_last  input  NREQ  bit i: the presented byte ends the message.
- req_ready  output  NREQ  bit i: byte accepted this cycle when req_valid[i] is also high.
- tx_full  input  1  UART TX FIFO full.
- wr_uart  output  1  write strobe into the UART TX FIFO.
- w_data  output  DBIT  byte written to the TX FIFO.
- grant_id  output  IDW  currently or most recently granted requester.
- busy  output  1  high while a message is in progress (state != IDLE).
- abort  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; grant_id = NREQ-1, so requester 0 has first priority.
  - stall counter = 0; abort = 0; busy = 0.
  - wr_uart = 0; req_ready = 0.
  - Reset mid-message abandons the message immediately; no further bytes are written.
- States:
  - IDLE -> GRANT when any req_valid is high.
  - In IDLE, the round-robin pick is registered into grant_id. The pick is the first requester with valid high, searching upward from grant_id+1 with wrap-around modulo NREQ.
  - GRANT -> DATA unconditionally after 1 cycle (HDR state is inserted when the optional feature is enabled).
  - In DATA, with g = grant_id:
    - req_ready[g] = ~tx_full (combinational); all other req_ready bits are 0.
    - wr_uart = req_valid[g] & ~tx_full.
    - w_data = req_data[g*DBIT +: DBIT].
  - DATA -> IDLE on an accepted byte with req_last[g] = 1. The same cycle's write completes.
- Latency: the first byte is written no earlier than cycle 2 after req_valid rises in IDLE. Each following byte is written in the cycle it is presented, if tx_full = 0.
- tx_full high: no write and no ready. The requester must hold valid/data/last stable until accepted. tx_full does not advance the stall counter.
- Stall watchdog, in DATA only:
  - The counter increments on cycles with req_valid[g] = 0 and clears on any cycle with req_valid[g] = 1.
  - When the counter reaches STALL_MAX: abort pulses for 1 cycle and state -> IDLE. Bytes already written stay written.
- Simultaneous events:
  - A requester dropping valid in IDLE before the pick is registered is not granted.
  - A last byte accepted on the same cycle the stall count would expire counts as acceptance; no abort.
- All outputs other than req_ready, wr_uart and w_data are registered.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- Defined:
  - Adds state HDR between GRANT and DATA.
  - In HDR, wr_uart = ~tx_full and w_data = HDR_BASE | grant_id; req_ready = 0.
  - HDR -> DATA once the header byte has been written.
  - The stall watchdog is inactive in HDR.
- Undefined: there is no HDR state and GRANT goes directly to DATA. No header byte is ever emitted.

Decomposition:
- Package uart_arb_pkg holds:
  - the state encoding constants S_IDLE, S_GRANT, S_HDR, S_DATA (2-bit);
  - HDR_BASE = 8'hA0;
  - the default STALL_MAX.
- Sub-module rr_pick: purely combinational round-robin picker. Inputs are the req vector and the previous grant; outputs are the next index and an any_req flag. It is reused by later arbiters.

Test Plan:
- Requester 0 sends 3 bytes 8'h41, 8'h42, 8'h43 (last on 8'h43), tx_full = 0 -> wr_uart high for 3 consecutive cycles starting at cycle 2 after valid; w_data sequence 41, 42, 43; busy falls the cycle after 43.
- Requesters 1 and 2 both valid from reset, each with a 2-byte message -> requester 1's 2 bytes, then requester 2's 2 bytes, never interleaved; grant_id goes 1 then 2. Repeat with all requesters valid -> grant order 0, 1, 2, 3, 0.
- tx_full held high for 5 cycles mid-message -> no wr_uart and req_ready = 0 during those cycles; data byte held and written once after tx_full falls; no abort.
- STALL_MAX = 4; requester 3 sends 1 byte without last, then drops valid -> abort pulses 4 cycles later; state returns to IDLE; next pending requester is granted.
- Reset asserted during byte 2 of a 4-byte message -> next cycle wr_uart = 0, grant_id = NREQ-1, busy = 0; no further bytes written.
- With UART_ARB_HDR_EN defined, requester 2 sends 8'h55 with last -> w_data sequence A2, 55.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional header byte per message is enabled with UART_ARB_HDR_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HDR   = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    localparam logic [7:0] HDR_BASE      = 8'hA0;
    localparam int         STALL_MAX_DEF = 255;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit above prev,
// wrapping modulo NREQ; prev itself is searched last.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  prev,
    output logic [IDW-1:0]  idx,
    output logic            any_req
);

    always_comb begin
        idx     = prev;
        any_req = |req;
        // Walk offsets downward so the nearest requester wins.
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(prev) + i) % NREQ]) begin
                idx = IDW'((int'(prev) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter for the UART TX FIFO write port.
// Define UART_ARB_HDR_EN to prefix each message with HDR_BASE | grant_id.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int DBIT      = 8,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [DBIT-1:0]      w_data,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 abort
);

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [15:0]    stall_q, stall_d;
    logic           abort_q, abort_d;
    logic           busy_q, busy_d;

    logic [IDW-1:0]  pick;
    logic            any_req;
    logic            g_valid;
    logic            g_last;
    logic [DBIT-1:0] g_data;

    rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_pick (
        .req    (req_valid),
        .prev   (grant_q),
        .idx    (pick),
        .any_req(any_req)
    );

    assign g_valid = req_valid[grant_q];
    assign g_last  = req_last[grant_q];
    assign g_data  = req_data[int'(grant_q)*DBIT +: DBIT];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        stall_d   = stall_q;
        abort_d   = 1'b0;
        wr_uart   = 1'b0;
        w_data    = '0;
        req_ready = '0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    stall_d = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
`ifdef UART_ARB_HDR_EN
                state_d = S_HDR;
`else
                state_d = S_DATA;
`endif
            end
            S_HDR: begin
`ifdef UART_ARB_HDR_EN
                wr_uart = ~tx_full;
                w_data  = DBIT'(HDR_BASE) | DBIT'(grant_q);
                if (!tx_full) state_d = S_DATA;
`else
                state_d = S_IDLE;
`endif
            end
            S_DATA: begin
                req_ready[grant_q] = ~tx_full;
                wr_uart = g_valid & ~tx_full;
                w_data  = g_data;
                if (g_valid) begin
                    stall_d = '0;
                    if (!tx_full && g_last) state_d = S_IDLE;
                end else if (!tx_full) begin
                    // Backpressure never counts toward the stall limit.
                    if (32'(stall_q) + 32'd1 >= 32'(STALL_MAX)) begin
                        stall_d = '0;
                        abort_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= IDW'(NREQ - 1);
            stall_q <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign abort    = abort_q;

endmodule
